// File: rtl/seg_scan_display.sv
// 8-digit multiplexed 7-segment driver showing one of eight 32-bit debug values in hex.
// Optional leading-zero blanking is enabled by defining SEG_BLANK_EN.
module seg_scan_display #(
   parameter int SCAN_DIV = 100000
) (
   input  logic        clk,
   input  logic        rst_,
   input  logic [2:0]  sel,
   input  logic        hold,
   input  logic [31:0] pc,
   input  logic [31:0] ir,
   input  logic [31:0] f,
   input  logic [31:0] w_data,
   input  logic [31:0] mdr,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        zf,
   input  logic        sf,
   input  logic        cf,
   input  logic        of,
   output logic [7:0]  AN,
   output logic [7:0]  Seg
);

   localparam int W = $clog2(SCAN_DIV);
   localparam logic [W-1:0] DIV_MAX = W'(SCAN_DIV - 1);

   logic [W-1:0] r_div_cnt;
   logic [2:0]   r_digit;
   logic [31:0]  r_snap;

   logic         w_tick;
   logic [2:0]   w_next_digit;
   logic         w_frame_start;
   logic [31:0]  w_mux;
   logic [31:0]  w_disp;
   logic [3:0]   w_nibble;
   logic [6:0]   w_seg7;
   logic         w_dp;
   logic         w_blank;

   assign w_tick        = (r_div_cnt == DIV_MAX);
   assign w_next_digit  = r_digit + 3'd1;
   assign w_frame_start = w_tick && (w_next_digit == 3'd0);

   always_comb begin
      w_mux = 32'd0;
      case (sel)
         3'd0:    w_mux = pc;
         3'd1:    w_mux = ir;
         3'd2:    w_mux = f;
         3'd3:    w_mux = w_data;
         3'd4:    w_mux = mdr;
         3'd5:    w_mux = a;
         3'd6:    w_mux = b;
         default: w_mux = {28'd0, zf, sf, cf, of};
      endcase
   end

   // Digit 0 is driven at the same edge that captures the snapshot, so it reads the mux directly.
   assign w_disp   = ((w_next_digit == 3'd0) && !hold) ? w_mux : r_snap;
   assign w_nibble = w_disp[{w_next_digit, 2'b00} +: 4];
   assign w_dp     = !((w_next_digit == 3'd0) && hold);

   always_comb begin
      w_seg7 = 7'h7F;
      case (w_nibble)
         4'h0: w_seg7 = 7'h40;
         4'h1: w_seg7 = 7'h79;
         4'h2: w_seg7 = 7'h24;
         4'h3: w_seg7 = 7'h30;
         4'h4: w_seg7 = 7'h19;
         4'h5: w_seg7 = 7'h12;
         4'h6: w_seg7 = 7'h02;
         4'h7: w_seg7 = 7'h78;
         4'h8: w_seg7 = 7'h00;
         4'h9: w_seg7 = 7'h10;
         4'hA: w_seg7 = 7'h08;
         4'hB: w_seg7 = 7'h03;
         4'hC: w_seg7 = 7'h46;
         4'hD: w_seg7 = 7'h21;
         4'hE: w_seg7 = 7'h06;
         4'hF: w_seg7 = 7'h0E;
         default: w_seg7 = 7'h7F;
      endcase
   end

`ifdef SEG_BLANK_EN
   // A digit is a leading zero when it and every nibble above it are zero; digit 0 always shows.
   assign w_blank = (w_next_digit != 3'd0) && ((w_disp >> {w_next_digit, 2'b00}) == 32'd0);
`else
   assign w_blank = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         r_div_cnt <= '0;
         r_digit   <= 3'd7;
         r_snap    <= 32'd0;
         AN        <= 8'hFF;
         Seg       <= 8'hFF;
      end else begin
         if (w_tick) begin
            r_div_cnt <= '0;
            r_digit   <= w_next_digit;
            if (w_frame_start && !hold) begin
               r_snap <= w_mux;
            end
            if (w_blank) begin
               AN  <= 8'hFF;
               Seg <= 8'hFF;
            end else begin
               AN  <= ~(8'b1 << w_next_digit);
               Seg <= {w_dp, w_seg7};
            end
         end else begin
            r_div_cnt <= r_div_cnt + W'(1);
         end
      end
   end

endmodule
